// File: rtl/mv_stream_loader.sv
// mv_stream_loader
//
// Front end of the matrix-vector engine. A 16-bit element stream (vector
// first, then the matrix row-major) is packed two elements per 32-bit BRAM
// word in the half-word layout the compute controller expects. After a
// correctly framed load it pulses pe_start. It then waits for pe_done and
// streams the N 32-bit results (BRAM words 0..N-1) out on an AXI-Stream
// master.
//
// The BRAM port is driven only while loading or draining; bram_own tells the
// surrounding mux when this block owns it.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   s_axis_*               element input stream (tlast on element N*N+N-1)
//   bram_addr/wrdata/we    BRAM port (byte address), 1-cycle read latency
//   bram_rddata            BRAM read data
//   bram_own               high while this block drives the BRAM port
//   pe_start / pe_done     handshake with the compute controller
//   m_axis_*               result output stream (tlast on result N-1)
//   busy                   not idle
//   err                    sticky framing error, cleared by the next load
module mv_stream_loader #(
  parameter int VECTOR_SIZE = 64,
  parameter int ELEM_WIDTH  = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ELEM_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [31:0]               bram_addr,
  output logic [2*ELEM_WIDTH-1:0]   bram_wrdata,
  output logic [3:0]                bram_we,
  input  logic [2*ELEM_WIDTH-1:0]   bram_rddata,
  output logic                      bram_own,
  output logic                      pe_start,
  input  logic                      pe_done,
  output logic [2*ELEM_WIDTH-1:0]   m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      busy,
  output logic                      err
);

  localparam int N         = VECTOR_SIZE;
  localparam int NUM_ELEMS = N * N + N;
  localparam int E_W       = $clog2(NUM_ELEMS);
  localparam int R_W       = (N > 1) ? $clog2(N) : 1;

  localparam logic [31:0]    N_U      = 32'(N);
  localparam logic [31:0]    HALF_V   = 32'(N / 2);
  localparam logic [31:0]    HALF_M   = 32'(N * N / 2);
  localparam logic [E_W-1:0] E_LAST   = E_W'(NUM_ELEMS - 1);
  localparam logic [R_W-1:0] R_LAST   = R_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN,
    ST_RDWAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [E_W-1:0]          e_q, e_d;
  logic [R_W-1:0]          r_q, r_d;
  logic                    err_q, err_d;
  logic [2*ELEM_WIDTH-1:0] tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;

  logic                    in_accept;
  logic [E_W-1:0]          e_cur;
  logic [31:0]             e_ext;
  logic [31:0]             j_ext;
  logic [31:0]             word_idx;
  logic                    high_half;
  logic                    beat_final;

  // Element index of the beat currently offered. The first beat taken in
  // IDLE is always element 0, so the counter value left over from a previous
  // (possibly aborted) load never matters.
  always_comb begin
    s_axis_tready = aresetn && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    in_accept     = s_axis_tvalid && s_axis_tready;
    e_cur         = (state_q == ST_IDLE) ? '0 : e_q;
    beat_final    = (e_cur == E_LAST);
  end

  // Element -> (word, half) mapping. The vector occupies words 0..N/2-1 with
  // v[i] and v[i+N/2] sharing a word; the matrix follows with m[j] and
  // m[j+N*N/2] sharing a word. Done with compares and subtracts so no
  // divider is needed for non-power-of-two sizes.
  always_comb begin
    e_ext     = 32'(e_cur);
    j_ext     = e_ext - N_U;
    word_idx  = '0;
    high_half = 1'b0;
    if (e_ext < N_U) begin
      if (e_ext < HALF_V) begin
        word_idx  = e_ext;
        high_half = 1'b1;
      end else begin
        word_idx  = e_ext - HALF_V;
        high_half = 1'b0;
      end
    end else begin
      if (j_ext < HALF_M) begin
        word_idx  = HALF_V + j_ext;
        high_half = 1'b1;
      end else begin
        word_idx  = HALF_V + j_ext - HALF_M;
        high_half = 1'b0;
      end
    end
  end

  // BRAM port and status outputs
  always_comb begin
    bram_own    = ((state_q == ST_IDLE) && in_accept) || (state_q == ST_LOAD) ||
                  (state_q == ST_DRAIN) || (state_q == ST_RDWAIT);
    bram_addr   = '0;
    bram_we     = '0;
    bram_wrdata = '0;
    if ((state_q == ST_DRAIN) || (state_q == ST_RDWAIT)) begin
      bram_addr = 32'(r_q) << 2;
    end else if (bram_own) begin
      bram_addr = word_idx << 2;
    end
    if (in_accept) begin
      if (high_half) begin
        bram_we     = 4'b1100;
        bram_wrdata = {s_axis_tdata, {ELEM_WIDTH{1'b0}}};
      end else begin
        bram_we     = 4'b0011;
        bram_wrdata = {{ELEM_WIDTH{1'b0}}, s_axis_tdata};
      end
    end
    pe_start      = (state_q == ST_START);
    busy          = (state_q != ST_IDLE);
    err           = err_q;
    m_axis_tdata  = tdata_q;
    m_axis_tvalid = tvalid_q;
    m_axis_tlast  = tvalid_q && (r_q == R_LAST);
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    r_d      = r_q;
    err_d    = err_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (in_accept) begin
          if (state_q == ST_IDLE) begin
            err_d = 1'b0;
          end
          e_d = e_cur + 1'b1;
          if (beat_final && s_axis_tlast) begin
            state_d = ST_START;
          end else if (beat_final || s_axis_tlast) begin
            // Framing error: the beat has already been written, abandon load.
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pe_done) begin
          r_d     = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        // First RDWAIT cycle captures the read data; the state then holds
        // the registered word until the consumer takes it.
        if (!tvalid_q) begin
          tdata_d  = bram_rddata;
          tvalid_d = 1'b1;
        end else if (m_axis_tready) begin
          tvalid_d = 1'b0;
          if (r_q == R_LAST) begin
            state_d = ST_IDLE;
          end else begin
            r_d     = r_q + 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      e_q      <= '0;
      r_q      <= '0;
      err_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      r_q      <= r_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_mv_stream_loader.sv
// Testbench for mv_stream_loader. Plays both the element source and the
// compute controller; owns a BRAM model shared with the DUT through the
// bram_own mux. Expected BRAM contents are derived word-by-word from the
// element list; expected results are whatever the controller side wrote.
module tb_mv_stream_loader;

  localparam int N  = 64;
  localparam int NE = N * N + N;
  localparam int NW = N / 2 + N * N / 2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [3:0]  bram_we;
  logic [31:0] bram_rddata;
  logic        bram_own;
  logic        pe_start;
  logic        pe_done;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        err;

  always #5 aclk = ~aclk;

  mv_stream_loader #(.VECTOR_SIZE(N), .ELEM_WIDTH(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .bram_addr     (bram_addr),
    .bram_wrdata   (bram_wrdata),
    .bram_we       (bram_we),
    .bram_rddata   (bram_rddata),
    .bram_own      (bram_own),
    .pe_start      (pe_start),
    .pe_done       (pe_done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .err           (err)
  );

  int tests = 0;
  int fails = 0;
  int pe_cnt = 0;
  int bus_viol = 0;

  logic [31:0] mem [0:4095];
  logic        ctl_we;
  logic [11:0] ctl_addr;
  logic [31:0] ctl_data;
  logic [15:0] elem [0:NE-1];
  logic [31:0] exp_res [0:N-1];

  // Shared BRAM: DUT side when it owns the port, controller side otherwise.
  always @(posedge aclk) begin
    if (bram_own) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_addr[13:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
      end
      bram_rddata <= mem[bram_addr[13:2]];
    end else begin
      if (ctl_we) mem[ctl_addr] <= ctl_data;
      bram_rddata <= mem[ctl_addr];
    end
  end

  // Bus-rule monitor and start-pulse counter.
  always @(negedge aclk) begin
    if (pe_start) pe_cnt <= pe_cnt + 1;
    if ((!bram_own && (bram_addr != 0 || bram_we != 0)) ||
        (bram_we != 0 && !(s_axis_tvalid && s_axis_tready)) ||
        (s_axis_tvalid && s_axis_tready && !bram_own))
      bus_viol <= bus_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++) elem[i] = 16'(i);
    for (int j = 0; j < N * N; j++) elem[N + j] = 16'(32'h1000 + j);
  endtask

  task automatic fill_random();
    for (int e = 0; e < NE; e++) elem[e] = 16'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_we"}, bram_we, 0);
    check({tag, "_addr"}, bram_addr, 0);
    check({tag, "_wrdata"}, bram_wrdata, 0);
    check({tag, "_own"}, bram_own, 0);
    check({tag, "_start"}, pe_start, 0);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Word w holds the two elements that share it: vector words pair v[w]
  // with v[w+N/2]; matrix words pair m[k] with m[k+N*N/2].
  task automatic check_mem(input string tag);
    int bad = 0;
    int first = -1;
    logic [31:0] ev;
    for (int w = 0; w < NW; w++) begin
      if (w < N / 2) ev = {elem[w], elem[w + N / 2]};
      else ev = {elem[N + w - N / 2], elem[N + w - N / 2 + N * N / 2]};
      if (mem[w] !== ev) begin
        bad++;
        if (first < 0) first = w;
      end
    end
    check($sformatf("%s_mem_bad_words(first %0d)", tag, first), bad, 0);
  endtask

  // Sends elements 0..n-1; tlast on element last_at. Starts and ends #1
  // after a rising edge.
  task automatic load(input int n, input int last_at, input bit gapped, output int acc);
    bit ok;
    acc = 0;
    for (int e = 0; e < n; e++) begin
      if (gapped && ($urandom_range(0, 1) == 1)) begin
        s_axis_tvalid = 1'b0;
        step(1);
      end
      s_axis_tdata  = elem[e];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (e == last_at);
      ok = 1'b0;
      for (int k = 0; k < 8 && !ok; k++) begin
        @(negedge aclk);
        ok = s_axis_tready;
        step(1);
      end
      if (!ok) break;
      acc++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic load_phase(input string tag, input bit gapped);
    int acc;
    int pc0;
    pc0 = pe_cnt;
    load(NE, NE - 1, gapped, acc);
    check({tag, "_accepted"}, acc, NE);
    @(negedge aclk);
    check({tag, "_pe_start_hi"}, pe_start, 1);
    step(1);
    @(negedge aclk);
    check({tag, "_pe_start_lo"}, pe_start, 0);
    check({tag, "_busy_wait"}, busy, 1);
    check({tag, "_own_wait"}, bram_own, 0);
    check({tag, "_err"}, err, 0);
    step(1);
    check({tag, "_pe_pulses"}, pe_cnt - pc0, 1);
    check_mem(tag);
  endtask

  task automatic receive(input string tag, input int nres, input bit rand_ready);
    int got = 0;
    int cyc = 0;
    bit pend = 0;
    logic [31:0] pend_d = '0;
    while (got < nres && cyc < 2000) begin
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge aclk);
      if (m_axis_tvalid) begin
        if (pend) check({tag, "_hold_tdata"}, m_axis_tdata, pend_d);
        if (m_axis_tready) begin
          check($sformatf("%s_res%0d", tag, got), m_axis_tdata, exp_res[got]);
          check($sformatf("%s_last%0d", tag, got), m_axis_tlast, 1'(got == N - 1));
          got++;
          pend = 1'b0;
        end else begin
          pend   = 1'b1;
          pend_d = m_axis_tdata;
        end
      end else if (pend) begin
        check({tag, "_hold_tvalid"}, m_axis_tvalid, 1);
      end
      step(1);
      cyc++;
    end
    m_axis_tready = 1'b0;
    check({tag, "_results_received"}, got, nres);
  endtask

  // Controller side: write results, pulse done, then collect nres results.
  task automatic drain_phase(input string tag, input int nres, input bit rand_ready, input bit const_res);
    for (int k = 0; k < N; k++) begin
      exp_res[k] = const_res ? (32'hA000_0000 + 32'(k)) : $urandom;
      ctl_we   = 1'b1;
      ctl_addr = 12'(k);
      ctl_data = exp_res[k];
      step(1);
    end
    ctl_we = 1'b0;
    pe_done = 1'b1;
    m_axis_tready = 1'b0;
    step(1);
    pe_done = 1'b0;
    @(negedge aclk);
    check({tag, "_lat_cycle1"}, m_axis_tvalid, 0);
    check({tag, "_own_drain"}, bram_own, 1);
    step(1);
    @(negedge aclk);
    check({tag, "_lat_cycle1b"}, m_axis_tvalid, 0);
    step(1);
    @(negedge aclk);
    check({tag, "_lat_cycle2"}, m_axis_tvalid, 1);
    step(1);
    receive(tag, nres, rand_ready);
    if (nres == N) begin
      @(negedge aclk);
      check({tag, "_idle_after"}, busy, 0);
      check({tag, "_tvalid_after"}, m_axis_tvalid, 0);
      step(1);
    end
  endtask

  initial begin
    int acc;
    int pc0;
    aresetn = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    pe_done = 1'b0;
    m_axis_tready = 1'b0;
    ctl_we = 1'b0;
    ctl_addr = '0;
    ctl_data = '0;

    // Reset values
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_reset_vals("rst0");
    step(1);
    aresetn = 1'b1;
    @(negedge aclk);
    check("idle_tready", s_axis_tready, 1);
    check("idle_busy", busy, 0);
    step(1);

    // pe_done outside WAIT is ignored
    pe_done = 1'b1;
    step(1);
    pe_done = 1'b0;
    step(3);
    @(negedge aclk);
    check("done_in_idle_busy", busy, 0);
    check("done_in_idle_tvalid", m_axis_tvalid, 0);
    step(1);

    // Full load with the reference pattern, then drain with 1,0,0,1 tready
    fill_pattern();
    load_phase("full", 1'b0);
    check("word0", mem[0], 32'h0000_0020);
    check("word31", mem[31], 32'h001F_003F);
    check("word32", mem[32], 32'h1000_1800);
    check("word2079", mem[2079], 32'h17FF_1FFF);
    drain_phase("drain_pat", N, 1'b0, 1'b1);

    // Early tlast at element 100
    fill_random();
    pc0 = pe_cnt;
    load(101, 100, 1'b0, acc);
    check("early_accepted", acc, 101);
    step(3);
    @(negedge aclk);
    check("early_err", err, 1);
    check("early_busy", busy, 0);
    check("early_tready", s_axis_tready, 1);
    step(1);
    check("early_no_start", pe_cnt - pc0, 0);

    // Gapped load of the reference pattern clears err and lands identically
    fill_pattern();
    load_phase("gapped", 1'b1);
    check("gapped_word2079", mem[2079], 32'h17FF_1FFF);
    drain_phase("drain_gap", N, 1'b1, 1'b0);

    // Missing tlast on the final element
    fill_random();
    pc0 = pe_cnt;
    load(NE, -1, 1'b0, acc);
    check("notlast_accepted", acc, NE);
    step(2);
    @(negedge aclk);
    check("notlast_err", err, 1);
    check("notlast_busy", busy, 0);
    step(1);
    check("notlast_no_start", pe_cnt - pc0, 0);

    // Reset in the middle of a load
    fill_random();
    load(1000, -1, 1'b0, acc);
    check("rstload_accepted", acc, 1000);
    s_axis_tdata  = elem[1000];
    s_axis_tvalid = 1'b1;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_reset_vals("rst_load");
    step(1);
    aresetn = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    check("rst_load_ready", s_axis_tready, 1);
    step(1);

    // Full random transaction
    fill_random();
    load_phase("rand1", 1'b0);
    drain_phase("drain_r1", N, 1'b1, 1'b0);

    // Reset in the middle of a drain (after result 9)
    fill_random();
    load_phase("rand2", 1'b0);
    drain_phase("drain_part", 10, 1'b1, 1'b0);
    aresetn = 1'b0;
    m_axis_tready = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_reset_vals("rst_drain");
    step(1);
    aresetn = 1'b1;
    step(1);

    // Full transaction after the aborted drain
    fill_random();
    load_phase("rand3", 1'b1);
    drain_phase("drain_r3", N, 1'b0, 1'b0);

    check("bus_rules", bus_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
